// File: rtl/mem_lsu_pkg.sv
// Shared op codes, widths and state encoding for the MEM-stage load/store unit.
// LL/SC decoding is enabled by MEM_LSU_LLSC_EN in the consuming modules.
package mem_lsu_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_W-1:0] ZERO_WORD     = '0;
    localparam logic             WRITE_ENABLE  = 1'b1;
    localparam logic             WRITE_DISABLE = 1'b0;

    localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [ALU_OP_W-1:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [ALU_OP_W-1:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: sel, store replication, load extraction, misalign.
// MEM_LSU_LLSC_EN adds LL (as a word load) and SC (as a word store) to the decode.
module mem_lane_align
    import mem_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB)
) (
    input  logic [ALU_OP_W-1:0] aluop,
    input  logic [31:0]         addr,
    input  logic [REG_W-1:0]    reg2,
    input  logic [DATA_W-1:0]   rdata,
    output logic                is_mem,
    output logic                is_load,
    output logic                misalign,
    output logic [31:0]         bus_addr,
    output logic [NB-1:0]       sel,
    output logic [DATA_W-1:0]   wdata,
    output logic [REG_W-1:0]    load_data
);

    localparam logic [NB-1:0] B_MASK = NB'(1) << (NB - 1);
    localparam logic [NB-1:0] H_MASK = NB'(2'b11) << (NB - 2);
    localparam logic [NB-1:0] W_MASK = NB'(4'hF) << (NB - 4);

    size_t          size;
    logic           sign;
    logic [LB-1:0]  k;
    logic [31:0]    win;

    always_comb begin
        is_mem  = 1'b1;
        is_load = 1'b0;
        size    = SZ_W;
        sign    = 1'b0;
        unique case (aluop)
            EXE_LB_OP:  begin is_load = 1'b1; size = SZ_B; sign = 1'b1; end
            EXE_LBU_OP: begin is_load = 1'b1; size = SZ_B; end
            EXE_LH_OP:  begin is_load = 1'b1; size = SZ_H; sign = 1'b1; end
            EXE_LHU_OP: begin is_load = 1'b1; size = SZ_H; end
            EXE_LW_OP:  is_load = 1'b1;
            EXE_SB_OP:  size = SZ_B;
            EXE_SH_OP:  size = SZ_H;
            EXE_SW_OP:  size = SZ_W;
`ifdef MEM_LSU_LLSC_EN
            EXE_LL_OP:  is_load = 1'b1;
            EXE_SC_OP:  size = SZ_W;
`endif
            default:    is_mem = 1'b0;
        endcase
    end

    assign k        = addr[LB-1:0];
    assign bus_addr = {addr[31:LB], {LB{1'b0}}};
    // Lane k moved to the top of the bus; the top 32 bits hold every access size.
    assign win      = 32'((rdata << {k, 3'b000}) >> (DATA_W - 32));

    always_comb begin
        misalign  = 1'b0;
        sel       = W_MASK >> k;
        wdata     = {(NB/4){reg2}};
        load_data = win;
        case (size)
            SZ_B: begin
                sel       = B_MASK >> k;
                wdata     = {NB{reg2[7:0]}};
                load_data = {{24{sign & win[31]}}, win[31:24]};
            end
            SZ_H: begin
                misalign  = addr[0];
                sel       = H_MASK >> k;
                wdata     = {(NB/2){reg2[15:0]}};
                load_data = {{16{sign & win[31]}}, win[31:16]};
            end
            default: misalign = addr[1:0] != 2'b00;
        endcase
        misalign = misalign & is_mem;
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack bus master with stall, exceptions and timeout.
// Define MEM_LSU_LLSC_EN to implement LL/SC with an internal LL bit.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int TIMEOUT_CYC = 255,
    localparam int NB          = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic                  llbit_clr_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  valid_o,
    output logic                  stall_req_o,
    output logic                  exc_adel_o,
    output logic                  exc_ades_o,
    output logic                  exc_bus_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [31:0]           bus_addr_o,
    output logic [NB-1:0]         bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic               tmo;
    logic               done_ack;
    logic               done_err;
    logic               accept_mem;
    logic               sc_fail;
    logic               is_mem;
    logic               is_load;
    logic               misalign;
    logic [31:0]        a_addr;
    logic [NB-1:0]      a_sel;
    logic [DATA_W-1:0]  a_wdata;
    logic [REG_W-1:0]   load_data;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .aluop     (aluop_i),
        .addr      (mem_addr_i),
        .reg2      (reg2_i),
        .rdata     (bus_rdata_i),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .misalign  (misalign),
        .bus_addr  (a_addr),
        .sel       (a_sel),
        .wdata     (a_wdata),
        .load_data (load_data)
    );

`ifdef MEM_LSU_LLSC_EN
    logic llbit;
    logic is_ll;
    logic is_sc;

    assign is_ll   = aluop_i == EXE_LL_OP;
    assign is_sc   = aluop_i == EXE_SC_OP;
    assign sc_fail = is_sc && !llbit;

    // A clear beats a simultaneous LL completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            llbit <= 1'b0;
        else if (llbit_clr_i)
            llbit <= 1'b0;
        else if (done_ack && is_ll)
            llbit <= 1'b1;
        else if (done_ack && is_sc)
            llbit <= 1'b0;
    end
`else
    logic unused_llclr;
    assign unused_llclr = llbit_clr_i;
    assign sc_fail      = 1'b0;
`endif

    assign accept_mem = valid_i && is_mem && !misalign && !sc_fail;
    assign tmo = (TIMEOUT_CYC != 0) && (int'(cnt) + 1 >= TIMEOUT_CYC);

    always_comb begin
        state_nxt   = state;
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        done_ack    = 1'b0;
        done_err    = 1'b0;
        unique case (state)
            IDLE: begin
                stall_req_o = rst && accept_mem;
                if (accept_mem)
                    state_nxt = WAIT;
            end
            WAIT: begin
                stall_req_o = 1'b1;
                bus_req_o   = 1'b1;
                if (bus_err_i || tmo) begin
                    done_err  = 1'b1;
                    state_nxt = DRAIN;
                end else if (bus_ack_i) begin
                    done_ack  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            wd_o        <= '0;
            wreg_o      <= WRITE_DISABLE;
            wdata_o     <= ZERO_WORD;
            exc_adel_o  <= 1'b0;
            exc_ades_o  <= 1'b0;
            exc_bus_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            state      <= state_nxt;
            valid_o    <= 1'b0;
            exc_adel_o <= 1'b0;
            exc_ades_o <= 1'b0;
            exc_bus_o  <= 1'b0;
            unique case (state)
                IDLE: if (valid_i) begin
                    wd_o    <= wd_i;
                    wreg_o  <= wreg_i;
                    wdata_o <= wdata_i;
                    if (misalign) begin
                        valid_o    <= 1'b1;
                        wreg_o     <= WRITE_DISABLE;
                        exc_adel_o <= is_load;
                        exc_ades_o <= !is_load;
                    end else if (sc_fail) begin
                        valid_o <= 1'b1;
                        wreg_o  <= WRITE_ENABLE;
                        wdata_o <= ZERO_WORD;
                    end else if (is_mem) begin
                        cnt         <= '0;
                        bus_we_o    <= !is_load;
                        bus_addr_o  <= a_addr;
                        bus_sel_o   <= a_sel;
                        bus_wdata_o <= a_wdata;
                    end else begin
                        valid_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != CW'(TIMEOUT_CYC))
                        cnt <= cnt + CW'(1);
                    if (done_err) begin
                        valid_o   <= 1'b1;
                        exc_bus_o <= 1'b1;
                        wreg_o    <= WRITE_DISABLE;
                    end else if (done_ack) begin
                        valid_o <= 1'b1;
                        wdata_o <= is_load ? load_data : wdata_i;
`ifdef MEM_LSU_LLSC_EN
                        if (is_sc)
                            wdata_o <= REG_W'(1);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: 32-bit instance (timeout 4) and 64-bit instance.
// LL/SC scenarios are exercised when MEM_LSU_LLSC_EN is defined.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2, wdata;
    logic [4:0]  wd;
    logic        wreg, llclr, ack, err;
    logic [31:0] rdata_a;
    logic [63:0] rdata_b;

    logic [4:0]  wd_o_a, wd_o_b;
    logic        wreg_o_a, wreg_o_b;
    logic [31:0] wdata_o_a, wdata_o_b;
    logic        valid_o_a, valid_o_b;
    logic        stall_a, stall_b;
    logic        adel_a, adel_b, ades_a, ades_b, ebus_a, ebus_b;
    logic        req_a, req_b, we_a, we_b;
    logic [31:0] baddr_a, baddr_b;
    logic [3:0]  sel_a;
    logic [7:0]  sel_b;
    logic [31:0] bwd_a;
    logic [63:0] bwd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_lsu #(.DATA_W(32), .TIMEOUT_CYC(4)) u_a (
        .clk(clk), .rst(rst), .valid_i(valid_a), .aluop_i(aluop),
        .mem_addr_i(addr), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
        .wdata_i(wdata), .llbit_clr_i(llclr), .wd_o(wd_o_a),
        .wreg_o(wreg_o_a), .wdata_o(wdata_o_a), .valid_o(valid_o_a),
        .stall_req_o(stall_a), .exc_adel_o(adel_a), .exc_ades_o(ades_a),
        .exc_bus_o(ebus_a), .bus_req_o(req_a), .bus_we_o(we_a),
        .bus_addr_o(baddr_a), .bus_sel_o(sel_a), .bus_wdata_o(bwd_a),
        .bus_ack_i(ack), .bus_err_i(err), .bus_rdata_i(rdata_a)
    );

    mem_lsu #(.DATA_W(64)) u_b (
        .clk(clk), .rst(rst), .valid_i(valid_b), .aluop_i(aluop),
        .mem_addr_i(addr), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
        .wdata_i(wdata), .llbit_clr_i(llclr), .wd_o(wd_o_b),
        .wreg_o(wreg_o_b), .wdata_o(wdata_o_b), .valid_o(valid_o_b),
        .stall_req_o(stall_b), .exc_adel_o(adel_b), .exc_ades_o(ades_b),
        .exc_bus_o(ebus_b), .bus_req_o(req_b), .bus_we_o(we_b),
        .bus_addr_o(baddr_b), .bus_sel_o(sel_b), .bus_wdata_o(bwd_b),
        .bus_ack_i(ack), .bus_err_i(err), .bus_rdata_i(rdata_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_a = 1'b1; valid_b = 1'b0; aluop = EXE_LW_OP;
        addr = 32'h1000; reg2 = '0; wdata = '0; wd = '0; wreg = 1'b0;
        llclr = 1'b0; ack = 1'b0; err = 1'b0; rdata_a = '0; rdata_b = '0;
        tick(); tick();
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_a); end
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", req_a); end
        n_cmp++; if (valid_o_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid_o_a); end
        n_cmp++; if ({wreg_o_a, wdata_o_a, wd_o_a} !== 38'd0) begin n_bad++; $display("FAIL rst_wb got %h/%h/%h want 0", wreg_o_a, wdata_o_a, wd_o_a); end
        n_cmp++; if ({sel_a, baddr_a, bwd_a, we_a} !== 69'd0) begin n_bad++; $display("FAIL rst_bus got %h/%h/%h want 0", sel_a, baddr_a, bwd_a); end
        n_cmp++; if ({adel_a, ades_a, ebus_a} !== 3'b000) begin n_bad++; $display("FAIL rst_exc got %b want 000", {adel_a, ades_a, ebus_a}); end
        valid_a = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_lb_zero_wait();
        tick();
        valid_a = 1'b1; aluop = EXE_LB_OP; addr = 32'h1001;
        rdata_a = 32'h1180_FF22; wd = 5'd3; wreg = 1'b1;
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL lb_stall_acc got %b want 1", stall_a); end
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL lb_req_acc got %b want 0", req_a); end
        tick();
        n_cmp++; if (req_a !== 1'b1 || stall_a !== 1'b1) begin n_bad++; $display("FAIL lb_wait got req %b stall %b want 1 1", req_a, stall_a); end
        n_cmp++; if (sel_a !== 4'b0100) begin n_bad++; $display("FAIL lb_sel got %b want 0100", sel_a); end
        n_cmp++; if (baddr_a !== 32'h1000 || we_a !== 1'b0) begin n_bad++; $display("FAIL lb_addr got %h we %b want 00001000 0", baddr_a, we_a); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1) begin n_bad++; $display("FAIL lb_valid got %b want 1", valid_o_a); end
        n_cmp++; if (wdata_o_a !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", wdata_o_a); end
        n_cmp++; if (wd_o_a !== 5'd3 || wreg_o_a !== 1'b1) begin n_bad++; $display("FAIL lb_dest got %h/%b want 03/1", wd_o_a, wreg_o_a); end
        n_cmp++; if (stall_a !== 1'b0 || req_a !== 1'b0) begin n_bad++; $display("FAIL lb_drain got stall %b req %b want 0 0", stall_a, req_a); end
        valid_a = 1'b0;
        tick();
        n_cmp++; if (valid_o_a !== 1'b0) begin n_bad++; $display("FAIL lb_valid_pulse got %b want 0", valid_o_a); end
    endtask

    task automatic test_loads();
        logic [7:0]  ops [5];
        logic [31:0] ads [5];
        logic [31:0] rds [5];
        logic [3:0]  sels [5];
        logic [31:0] exps [5];
        ops  = '{EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LB_OP};
        ads  = '{32'h1003, 32'h1002, 32'h1000, 32'h1004, 32'h1000};
        rds  = '{32'h1122_3384, 32'h1234_8001, 32'h9ABC_0000, 32'hDEAD_BEEF, 32'h7F00_0000};
        sels = '{4'b0001, 4'b0011, 4'b1100, 4'b1111, 4'b1000};
        exps = '{32'h0000_0084, 32'hFFFF_8001, 32'h0000_9ABC, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            tick();
            valid_a = 1'b1; aluop = ops[i]; addr = ads[i]; rdata_a = rds[i];
            tick();
            n_cmp++; if (sel_a !== sels[i]) begin n_bad++; $display("FAIL load%0d_sel got %b want %b", i, sel_a, sels[i]); end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== exps[i]) begin n_bad++; $display("FAIL load%0d_data got %b/%h want 1/%h", i, valid_o_a, wdata_o_a, exps[i]); end
            valid_a = 1'b0;
            tick();
        end
    endtask

    task automatic test_stores();
        tick();
        valid_a = 1'b1; aluop = EXE_SW_OP; addr = 32'h1008;
        reg2 = 32'hCAFE_F00D; wdata = 32'h55; wreg = 1'b0;
        tick();
        n_cmp++; if (we_a !== 1'b1 || sel_a !== 4'hF || bwd_a !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sw_bus got %b/%b/%h want 1/1111/cafef00d", we_a, sel_a, bwd_a); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h55) begin n_bad++; $display("FAIL sw_wb got %b/%h want 1/00000055", valid_o_a, wdata_o_a); end
        valid_a = 1'b0;
        tick();
        tick();
        valid_a = 1'b1; aluop = EXE_SB_OP; addr = 32'h1002; reg2 = 32'h1234_5678;
        tick();
        n_cmp++; if (sel_a !== 4'b0010 || bwd_a !== 32'h7878_7878) begin n_bad++; $display("FAIL sb32_bus got %b/%h want 0010/78787878", sel_a, bwd_a); end
        ack = 1'b1;
        tick();
        ack = 1'b0; valid_a = 1'b0;
        tick();
        tick();
        valid_b = 1'b1; aluop = EXE_SH_OP; addr = 32'h2006; reg2 = 32'hAAAA_BEEF;
        tick();
        n_cmp++; if (baddr_b !== 32'h2000) begin n_bad++; $display("FAIL sh64_addr got %h want 00002000", baddr_b); end
        n_cmp++; if (sel_b !== 8'b0000_0011) begin n_bad++; $display("FAIL sh64_sel got %b want 00000011", sel_b); end
        n_cmp++; if (bwd_b !== 64'hBEEF_BEEF_BEEF_BEEF || we_b !== 1'b1) begin n_bad++; $display("FAIL sh64_wdata got %h we %b want beefbeefbeefbeef 1", bwd_b, we_b); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (valid_o_b !== 1'b1) begin n_bad++; $display("FAIL sh64_valid got %b want 1", valid_o_b); end
        valid_b = 1'b0;
        tick();
        tick();
        valid_b = 1'b1; aluop = EXE_SB_OP; addr = 32'h2003; reg2 = 32'h0000_005A;
        tick();
        n_cmp++; if (sel_b !== 8'b0001_0000 || bwd_b !== 64'h5A5A_5A5A_5A5A_5A5A) begin n_bad++; $display("FAIL sb64_bus got %b/%h want 00010000/5a5a5a5a5a5a5a5a", sel_b, bwd_b); end
        ack = 1'b1;
        tick();
        ack = 1'b0; valid_b = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        tick();
        valid_a = 1'b1; aluop = EXE_LW_OP; addr = 32'h3002; wreg = 1'b1;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL adel_stall got %b want 0", stall_a); end
        tick();
        valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || adel_a !== 1'b1 || ades_a !== 1'b0) begin n_bad++; $display("FAIL adel_exc got v%b adel%b ades%b want 1 1 0", valid_o_a, adel_a, ades_a); end
        n_cmp++; if (wreg_o_a !== 1'b0 || req_a !== 1'b0) begin n_bad++; $display("FAIL adel_wreg got %b req %b want 0 0", wreg_o_a, req_a); end
        tick();
        n_cmp++; if (adel_a !== 1'b0 || valid_o_a !== 1'b0) begin n_bad++; $display("FAIL adel_pulse got %b/%b want 0/0", adel_a, valid_o_a); end
        valid_a = 1'b1; aluop = EXE_SH_OP; addr = 32'h3001;
        tick();
        valid_a = 1'b0;
        n_cmp++; if (ades_a !== 1'b1 || adel_a !== 1'b0 || req_a !== 1'b0) begin n_bad++; $display("FAIL ades_exc got ades%b adel%b req%b want 1 0 0", ades_a, adel_a, req_a); end
        tick();
    endtask

    task automatic test_passthrough();
        tick();
        valid_a = 1'b1; aluop = EXE_ADD_OP; addr = 32'h3003;
        wd = 5'd7; wreg = 1'b1; wdata = 32'h1234_ABCD;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL add_stall got %b want 0", stall_a); end
        tick();
        valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h1234_ABCD) begin n_bad++; $display("FAIL add_wb got %b/%h want 1/1234abcd", valid_o_a, wdata_o_a); end
        n_cmp++; if (wd_o_a !== 5'd7 || wreg_o_a !== 1'b1 || adel_a !== 1'b0) begin n_bad++; $display("FAIL add_dest got %h/%b/%b want 07/1/0", wd_o_a, wreg_o_a, adel_a); end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        cyc = 0;
        tick();
        valid_a = 1'b1; aluop = EXE_LW_OP; addr = 32'h1000; wreg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_a === 1'b1) cyc++;
            else break;
        end
        valid_a = 1'b0;
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL tmo_cycles got %0d want 4", cyc); end
        n_cmp++; if (ebus_a !== 1'b1 || valid_o_a !== 1'b1 || wreg_o_a !== 1'b0) begin n_bad++; $display("FAIL tmo_exc got bus%b v%b wreg%b want 1 1 0", ebus_a, valid_o_a, wreg_o_a); end
        tick();
        n_cmp++; if (ebus_a !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got %b want 0", ebus_a); end
    endtask

    task automatic test_err_ack();
        tick();
        valid_a = 1'b1; aluop = EXE_LW_OP; addr = 32'h1000; wreg = 1'b1;
        rdata_a = 32'h0BAD_0BAD;
        tick();
        ack = 1'b1; err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        n_cmp++; if (ebus_a !== 1'b1 || wreg_o_a !== 1'b0 || valid_o_a !== 1'b1) begin n_bad++; $display("FAIL errack got bus%b wreg%b v%b want 1 0 1", ebus_a, wreg_o_a, valid_o_a); end
        valid_a = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        tick();
        valid_a = 1'b1; aluop = EXE_LW_OP; addr = 32'h1000;
        tick();
        n_cmp++; if (req_a !== 1'b1) begin n_bad++; $display("FAIL rstw_pre got %b want 1", req_a); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (req_a !== 1'b0 || stall_a !== 1'b0) begin n_bad++; $display("FAIL rstw_drop got req %b stall %b want 0 0", req_a, stall_a); end
        valid_a = 1'b0;
        tick();
        rst = 1'b1;
        valid_a = 1'b1; aluop = EXE_ADD_OP; wd = 5'd9; wreg = 1'b1; wdata = 32'h42;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL rstw_add_stall got %b want 0", stall_a); end
        tick();
        valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h42) begin n_bad++; $display("FAIL rstw_add got %b/%h want 1/00000042", valid_o_a, wdata_o_a); end
        tick();
    endtask

`ifdef MEM_LSU_LLSC_EN
    task automatic test_llsc();
        tick();
        valid_a = 1'b1; aluop = EXE_LL_OP; addr = 32'h1010; rdata_a = 32'h1111_1111; wreg = 1'b1;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0; valid_a = 1'b0;
        n_cmp++; if (wdata_o_a !== 32'h1111_1111) begin n_bad++; $display("FAIL ll_data got %h want 11111111", wdata_o_a); end
        tick();
        llclr = 1'b1;
        tick();
        llclr = 1'b0;
        valid_a = 1'b1; aluop = EXE_SC_OP; reg2 = 32'h99; wdata = 32'h77;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL scf_stall got %b want 0", stall_a); end
        tick();
        valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h0 || wreg_o_a !== 1'b1 || req_a !== 1'b0) begin n_bad++; $display("FAIL scf_wb got v%b %h wreg%b req%b want 1 00000000 1 0", valid_o_a, wdata_o_a, wreg_o_a, req_a); end
        tick();
        valid_a = 1'b1; aluop = EXE_LL_OP;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0; valid_a = 1'b0;
        tick();
        valid_a = 1'b1; aluop = EXE_SC_OP;
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL scs_stall got %b want 1", stall_a); end
        tick();
        n_cmp++; if (req_a !== 1'b1 || we_a !== 1'b1 || bwd_a !== 32'h99) begin n_bad++; $display("FAIL scs_bus got req%b we%b %h want 1 1 00000099", req_a, we_a, bwd_a); end
        ack = 1'b1;
        tick();
        ack = 1'b0; valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h1) begin n_bad++; $display("FAIL scs_wb got %b/%h want 1/00000001", valid_o_a, wdata_o_a); end
        tick();
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_cmp++; if (wdata_o_a !== 32'h0 || valid_o_a !== 1'b1) begin n_bad++; $display("FAIL sc_again got %b/%h want 1/00000000", valid_o_a, wdata_o_a); end
        tick();
        valid_a = 1'b1; aluop = EXE_LL_OP;
        tick();
        ack = 1'b1; llclr = 1'b1;
        tick();
        ack = 1'b0; llclr = 1'b0; valid_a = 1'b0;
        tick();
        valid_a = 1'b1; aluop = EXE_SC_OP;
        tick();
        valid_a = 1'b0;
        n_cmp++; if (wdata_o_a !== 32'h0 || req_a !== 1'b0) begin n_bad++; $display("FAIL clr_wins got %h req%b want 00000000 0", wdata_o_a, req_a); end
        tick();
    endtask
`else
    task automatic test_ll_passthrough();
        tick();
        valid_a = 1'b1; aluop = EXE_LL_OP; addr = 32'h1001; wdata = 32'h0000_CAFE; wreg = 1'b1;
        #1;
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL ll_pt_stall got %b want 0", stall_a); end
        tick();
        valid_a = 1'b0;
        n_cmp++; if (valid_o_a !== 1'b1 || wdata_o_a !== 32'h0000_CAFE || adel_a !== 1'b0) begin n_bad++; $display("FAIL ll_pt_wb got v%b %h adel%b want 1 0000cafe 0", valid_o_a, wdata_o_a, adel_a); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_lb_zero_wait();
        test_loads();
        test_stores();
        test_misalign();
        test_passthrough();
        test_timeout();
        test_err_ack();
        test_reset_mid_wait();
`ifdef MEM_LSU_LLSC_EN
        test_llsc();
`else
        test_ll_passthrough();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
